mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single 64-bit-line backing-memory port between the instruction cache and the data cache. Each cache issues line reads, and the data cache also issues word or line writes, using the same read/write/size/ready handshake it would drive to memory directly. The arbiter sits between the two caches and the memory model. It registers a grant, forwards only the granted cache's request, routes the memory's ready pulse back to that cache, and keeps per-port saturating grant counters for performance analysis.

## Interface
Parameters:
- WORD_SIZE, 16, address and CPU word width
- LINE_SIZE, 64, memory data width (one cache line)
- STARVE_LIMIT, 2, max consecutive D grants while I is waiting; range 1..15

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- i__read_m  in  1  I-cache line-read request; held high until i__ready
- i__addr  in  WORD_SIZE  I-cache request address
- i__ready  out  1  one-cycle pulse: I request complete, m__rdata valid
- d__read_m  in  1  D-cache read request; held until d__ready
- d__write_m  in  1  D-cache write request; held until d__ready
- d__addr  in  WORD_SIZE  D-cache request address
- d__size  in  WORD_SIZE  D-cache transfer size in bits (WORD_SIZE or LINE_SIZE)
- d__wdata  in  LINE_SIZE  D-cache write data
- d__ready  out  1  one-cycle pulse: D request complete
- m__read_m  out  1  memory read strobe
- m__write_m  out  1  memory write strobe
- m__addr  out  WORD_SIZE  memory address
- m__size  out  WORD_SIZE  memory transfer size
- m__wdata  out  LINE_SIZE  memory write data
- m__ready  in  1  memory completion pulse (exactly one cycle)
- m__rdata  in  LINE_SIZE  memory read data; valid while m__ready=1
- o__grant  out  2  current grant: 00 none, 01 I, 10 D
- o__i_grants  out  16  saturating count of completed I transactions
- o__d_grants  out  16  saturating count of completed D transactions

## Operation
- States: IDLE, GRANT_I, GRANT_D, TURN. State is registered; o__grant decodes the state (TURN and IDLE give 00).
- IDLE: evaluate pending requests at posedge. I pending = i__read_m. D pending = d__read_m | d__write_m.
  - Only I pending -> GRANT_I.
  - Only D pending -> GRANT_D.
  - Both pending -> GRANT_I if streak >= STARVE_LIMIT, else GRANT_D.
  - Neither pending -> stay in IDLE.
- GRANT_I: m__read_m = i__read_m, m__write_m = 0, m__addr = i__addr, m__size = LINE_SIZE, m__wdata = 0.
- GRANT_D: m__read_m = d__read_m & ~d__write_m, m__write_m = d__write_m, m__addr = d__addr, m__size = d__size, m__wdata = d__wdata. If read and write are both high, the request is treated as a write.
- In IDLE and TURN, all m__ outputs are 0.
- Ready routing: i__ready = m__ready & GRANT_I; d__ready = m__ready & GRANT_D. m__ready outside a grant is ignored. m__rdata is not registered; it is routed to both caches, and each cache qualifies it with its own ready.
- Completion: m__ready in GRANT_x -> TURN. TURN -> IDLE unconditionally. TURN gives memory one idle cycle with both strobes low between transactions.
- Streak counter (4 bits): on a D completion while i__read_m=1, streak +1 (saturates at 15). On an I completion, or any cycle with i__read_m=0, streak clears to 0.
- Grant counters: +1 on each completion of the matching port; hold at 16'hFFFF.
- Requester dropping its strobe mid-grant (protocol violation): the strobe deassertion is forwarded as-is, and the grant is held until m__ready.

## Timing
- Arbitration latency: a request seen at posedge N in IDLE drives the memory strobe from cycle N+1. This is a combinational forward of the registered grant.
- Back-to-back: ready at posedge K -> TURN in cycle K+1 -> IDLE in cycle K+2, re-arbitration at posedge K+2 -> next strobe in cycle K+3. Minimum gap between transactions is 2 idle cycles.
- A ready pulse and a new request from the other port in the same cycle: the new request waits; the next decision is made in IDLE.
- Reset (reset_n=0, asynchronous): state IDLE, streak 0, both grant counters 0, all m__ outputs 0, i__ready=d__ready=0, o__grant=00.
  - Reset mid-transaction abandons the grant immediately. Strobes drop without waiting for the cycle edge.
  - A late m__ready after reset is ignored.
- Release of reset is synchronous to clk; first arbitration happens at the first posedge with reset_n=1.

## Test plan
- Reset behaviour: assert reset_n=0 during GRANT_D with d__write_m=1 -> m__write_m=0 and o__grant=00 within the same cycle; both counters read 0 after release.
- Single I read: i__read_m=1, i__addr=16'h0040, memory ready after 4 cycles -> m__read_m=1, m__size=64, m__addr=16'h0040 from cycle 1; i__ready pulses once; then 2 idle cycles; o__i_grants=1.
- D word write: d__write_m=1, d__size=16, d__wdata=64'h1234 -> m__write_m=1, m__wdata=64'h1234; d__ready pulses; i__ready stays 0.
- Contention and starvation, STARVE_LIMIT=2: I and D both hold requests continuously -> grant order D, D, I, D, D, I; the streak clears after each I grant.
- Stray ready: m__ready pulsed while in IDLE -> no ready output, counters unchanged.
- Counter saturation: force 65536 D completions -> o__d_grants holds at 16'hFFFF; o__i_grants is unaffected.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the three buses around the backing-memory
// arbiter: the I-cache port (i__*), the D-cache port (d__*), the memory port
// (m__*) and the observability outputs (o__*).
//   slave  : the arbiter's view (takes cache requests, drives memory)
//   master : the environment's view (caches + memory model)
// m__rdata is not registered or muxed by the arbiter. Both caches read it
// straight off this bundle and qualify it with their own ready, so it appears
// only in the master modport.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int LINE_SIZE = 64
);
  logic                 i__read_m;
  logic [WORD_SIZE-1:0] i__addr;
  logic                 i__ready;

  logic                 d__read_m;
  logic                 d__write_m;
  logic [WORD_SIZE-1:0] d__addr;
  logic [WORD_SIZE-1:0] d__size;
  logic [LINE_SIZE-1:0] d__wdata;
  logic                 d__ready;

  logic                 m__read_m;
  logic                 m__write_m;
  logic [WORD_SIZE-1:0] m__addr;
  logic [WORD_SIZE-1:0] m__size;
  logic [LINE_SIZE-1:0] m__wdata;
  logic                 m__ready;
  logic [LINE_SIZE-1:0] m__rdata;

  logic [1:0]           o__grant;
  logic [15:0]          o__i_grants;
  logic [15:0]          o__d_grants;

  modport slave (
    input  i__read_m, i__addr,
    input  d__read_m, d__write_m, d__addr, d__size, d__wdata,
    input  m__ready,
    output i__ready, d__ready,
    output m__read_m, m__write_m, m__addr, m__size, m__wdata,
    output o__grant, o__i_grants, o__d_grants
  );

  modport master (
    output i__read_m, i__addr,
    output d__read_m, d__write_m, d__addr, d__size, d__wdata,
    output m__ready, m__rdata,
    input  i__ready, d__ready,
    input  m__read_m, m__write_m, m__addr, m__size, m__wdata,
    input  o__grant, o__i_grants, o__d_grants
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between the I-cache
// (line reads) and the D-cache (word/line reads and writes).
// Ports:
//   clk      clock, all state changes on posedge
//   reset_n  asynchronous active-low reset
//   bus      mem_port_arbiter_if.slave (cache requests in, memory strobes
//            out, ready routing, grant state and saturating grant counters)
// A registered grant selects which cache is combinationally forwarded to
// memory. After each completion one TURN cycle keeps both strobes low before
// the next arbitration. D wins ties unless it has completed STARVE_LIMIT
// times in a row while I was waiting.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int LINE_SIZE    = 64,
  parameter int STARVE_LIMIT = 2
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    TURN    = 2'd3
  } state_t;

  localparam logic [WORD_SIZE-1:0] LINE_BITS = WORD_SIZE'(LINE_SIZE);
  localparam logic [3:0]           STARVE_LIM = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [3:0]  streak;
  logic [15:0] i_grants, d_grants;
  logic        i_pend, d_pend, i_done, d_done;

  assign i_pend = bus.i__read_m;
  assign d_pend = bus.d__read_m | bus.d__write_m;
  assign i_done = (state == GRANT_I) & bus.m__ready;
  assign d_done = (state == GRANT_D) & bus.m__ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the memory-side forward. Because this decodes the
  // registered state, an async reset drops the strobes immediately.
  always_comb begin
    state_nxt      = state;
    bus.m__read_m  = 1'b0;
    bus.m__write_m = 1'b0;
    bus.m__addr    = '0;
    bus.m__size    = '0;
    bus.m__wdata   = '0;
    bus.i__ready   = 1'b0;
    bus.d__ready   = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && d_pend)
          state_nxt = (streak >= STARVE_LIM) ? GRANT_I : GRANT_D;
        else if (i_pend)
          state_nxt = GRANT_I;
        else if (d_pend)
          state_nxt = GRANT_D;
      end
      GRANT_I: begin
        // A requester dropping its strobe mid-grant is forwarded as-is; the
        // grant is only released by m__ready.
        bus.m__read_m = bus.i__read_m;
        bus.m__addr   = bus.i__addr;
        bus.m__size   = LINE_BITS;
        bus.i__ready  = bus.m__ready;
        if (bus.m__ready) state_nxt = TURN;
      end
      GRANT_D: begin
        // read+write together is treated as a write
        bus.m__read_m  = bus.d__read_m & ~bus.d__write_m;
        bus.m__write_m = bus.d__write_m;
        bus.m__addr    = bus.d__addr;
        bus.m__size    = bus.d__size;
        bus.m__wdata   = bus.d__wdata;
        bus.d__ready   = bus.m__ready;
        if (bus.m__ready) state_nxt = TURN;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o__grant = (state == GRANT_I) ? 2'b01 :
                        (state == GRANT_D) ? 2'b10 : 2'b00;

  // Streak counts D completions that happened while I sat waiting. It only
  // survives while I keeps requesting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  streak <= '0;
    else if (!i_pend || i_done)    streak <= '0;
    else if (d_done && streak != 4'hF) streak <= streak + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_grants <= '0;
      d_grants <= '0;
    end else begin
      if (i_done && i_grants != 16'hFFFF) i_grants <= i_grants + 16'd1;
      if (d_done && d_grants != 16'hFFFF) d_grants <= d_grants + 16'd1;
    end
  end

  assign bus.o__i_grants = i_grants;
  assign bus.o__d_grants = d_grants;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. A transaction-level
// reference (owner / turnaround gap / streak / counters) predicts every output
// each cycle, and literal checks pin the key scenarios.
module tb_mem_port_arbiter;
  localparam int WS = 16;
  localparam int LS = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WORD_SIZE(WS), .LINE_SIZE(LS)) bus ();

  mem_port_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .STARVE_LIMIT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Memory responder: pulses m__ready once the strobe has been seen for
  // mem_lat cycles. When disabled, m__ready follows 'stray' directly.
  logic mem_en = 1'b0;
  logic stray  = 1'b0;
  int   mem_lat = 1;
  int   mcnt = 0;
  initial begin
    bus.m__ready = 1'b0;
    bus.m__rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (mem_en) begin
        if (bus.m__ready) begin
          bus.m__ready = 1'b0;
          mcnt = 0;
        end else if (bus.m__read_m || bus.m__write_m) begin
          mcnt++;
          if (mcnt >= mem_lat) begin
            bus.m__ready = 1'b1;
            bus.m__rdata = {4{bus.m__addr}};
          end
        end else mcnt = 0;
      end else begin
        bus.m__ready = stray;
        mcnt = 0;
      end
    end
  end

  // Reference: who owns the port (0 none, 1 I, 2 D), how many idle cycles
  // must pass before the next decision, and the fairness / count bookkeeping.
  int   own, gap, streak, ic, dc;
  logic preset_req = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own <= 0; gap <= 0; streak <= 0; ic <= 0; dc <= 0;
    end else begin
      if (own != 0) begin
        if (bus.m__ready) begin
          own <= 0;
          gap <= 1;
          if (own == 1) ic <= (ic < 65535) ? ic + 1 : 65535;
          else          dc <= (dc < 65535) ? dc + 1 : 65535;
        end
      end else if (gap > 0) begin
        gap <= gap - 1;
      end else begin
        if (bus.i__read_m && (bus.d__read_m || bus.d__write_m)) own <= (streak >= 2) ? 1 : 2;
        else if (bus.i__read_m)                                 own <= 1;
        else if (bus.d__read_m || bus.d__write_m)               own <= 2;
      end
      if (!bus.i__read_m || (own == 1 && bus.m__ready)) streak <= 0;
      else if (own == 2 && bus.m__ready)                streak <= (streak < 15) ? streak + 1 : 15;
      if (preset_req) dc <= 65533;
    end
  end

  // Per-cycle comparison against the reference; also logs completion order.
  int order[$];
  initial begin
    forever begin
      logic        e_rd, e_wr, e_ir, e_dr;
      logic [15:0] e_addr, e_size;
      logic [63:0] e_wd;
      @(negedge clk); #2;
      e_rd   = (own == 1) ? bus.i__read_m : (own == 2) ? (bus.d__read_m & ~bus.d__write_m) : 1'b0;
      e_wr   = (own == 2) ? bus.d__write_m : 1'b0;
      e_addr = (own == 1) ? bus.i__addr : (own == 2) ? bus.d__addr : 16'h0;
      e_size = (own == 1) ? 16'd64 : (own == 2) ? bus.d__size : 16'h0;
      e_wd   = (own == 2) ? bus.d__wdata : 64'h0;
      e_ir   = (own == 1) && bus.m__ready;
      e_dr   = (own == 2) && bus.m__ready;
      chk("grant",    bus.o__grant, 64'(own));
      chk("m_read",   bus.m__read_m, e_rd);
      chk("m_write",  bus.m__write_m, e_wr);
      chk("m_addr",   bus.m__addr, e_addr);
      chk("m_size",   bus.m__size, e_size);
      chk("m_wdata",  bus.m__wdata, e_wd);
      chk("i_ready",  bus.i__ready, e_ir);
      chk("d_ready",  bus.d__ready, e_dr);
      chk("i_grants", bus.o__i_grants, 64'(ic));
      chk("d_grants", bus.o__d_grants, 64'(dc));
      if (bus.i__ready) order.push_back(1);
      if (bus.d__ready) order.push_back(2);
    end
  end

  task automatic wait_rdy(input bit is_i, input int lim);
    bit seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk); #3;
      seen = is_i ? bus.i__ready : bus.d__ready;
    end
    chk(is_i ? "i_ready_timeout" : "d_ready_timeout", 64'(seen), 64'd1);
  endtask

  task automatic i_txn(input logic [15:0] addr);
    @(negedge clk);
    bus.i__read_m = 1'b1; bus.i__addr = addr;
    @(negedge clk); #3;
    chk("i_first_strobe", bus.m__read_m, 1);
    chk("i_first_addr",   bus.m__addr, addr);
    chk("i_first_size",   bus.m__size, 64);
    wait_rdy(1'b1, 30);
    @(negedge clk);
    bus.i__read_m = 1'b0;
    #3 chk("i_turn_quiet", {bus.m__read_m, bus.m__write_m, bus.o__grant}, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic d_txn(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] size, input logic [63:0] wd);
    @(negedge clk);
    bus.d__read_m = rd; bus.d__write_m = wr; bus.d__addr = addr;
    bus.d__size = size; bus.d__wdata = wd;
    @(negedge clk); #3;
    chk("d_first_write", bus.m__write_m, wr);
    chk("d_first_read",  bus.m__read_m, rd & ~wr);
    chk("d_first_wdata", bus.m__wdata, wd);
    chk("d_no_i_ready",  bus.i__ready, 0);
    wait_rdy(1'b0, 30);
    @(negedge clk);
    bus.d__read_m = 1'b0; bus.d__write_m = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int exp_order[6] = '{2, 2, 1, 2, 2, 1};
    bus.i__read_m = 1'b0; bus.i__addr = '0;
    bus.d__read_m = 1'b0; bus.d__write_m = 1'b0; bus.d__addr = '0;
    bus.d__size = '0; bus.d__wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_grant", bus.o__grant, 0);
    chk("rst_strobes", {bus.m__read_m, bus.m__write_m, bus.i__ready, bus.d__ready}, 0);
    chk("rst_counts", {bus.o__i_grants, bus.o__d_grants}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // reset in the middle of a D write grant
    mem_en = 1'b0;
    bus.d__write_m = 1'b1; bus.d__size = 16'd16; bus.d__addr = 16'h0200; bus.d__wdata = 64'hABCD;
    repeat (2) @(negedge clk);
    #3;
    chk("pre_rst_write", bus.m__write_m, 1);
    chk("pre_rst_grant", bus.o__grant, 2);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_write", bus.m__write_m, 0);
    chk("mid_rst_grant", bus.o__grant, 0);
    @(negedge clk);
    bus.d__write_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #3 chk("post_rst_counts", {bus.o__i_grants, bus.o__d_grants}, 0);

    // single I read, memory ready after 4 cycles
    mem_en = 1'b1; mem_lat = 4;
    i_txn(16'h0040);
    chk("i_count_1", bus.o__i_grants, 1);

    // D word write, D read+write (write wins), D line read
    mem_lat = 2;
    d_txn(1'b0, 1'b1, 16'h0100, 16'd16, 64'h1234);
    chk("d_count_1", bus.o__d_grants, 1);
    d_txn(1'b1, 1'b1, 16'h0108, 16'd16, 64'h5678);
    d_txn(1'b1, 1'b0, 16'h0300, 16'd64, 64'h0);
    chk("d_count_3", bus.o__d_grants, 3);

    // contention with both requests held continuously
    mem_lat = 1;
    order.delete();
    @(negedge clk);
    bus.i__read_m = 1'b1; bus.i__addr = 16'h0500;
    bus.d__read_m = 1'b1; bus.d__addr = 16'h0600; bus.d__size = 16'd64;
    for (int k = 0; k < 200 && order.size() < 6; k++) begin
      @(negedge clk); #3;
    end
    @(negedge clk);
    bus.i__read_m = 1'b0; bus.d__read_m = 1'b0;
    repeat (2) @(negedge clk);
    chk("order_len", 64'(order.size()), 6);
    for (int k = 0; k < 6 && k < order.size(); k++) begin
      chk($sformatf("order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
    end
    chk("cont_i_count", bus.o__i_grants, 3);
    chk("cont_d_count", bus.o__d_grants, 7);

    // stray ready in IDLE
    mem_en = 1'b0;
    @(negedge clk);
    stray = 1'b1;
    #3 chk("stray_no_ready", {bus.i__ready, bus.d__ready}, 0);
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    #3 chk("stray_counts", {bus.o__i_grants, bus.o__d_grants}, {16'd3, 16'd7});

    // requester drops its strobe mid-grant: grant is held until ready
    @(negedge clk);
    bus.d__read_m = 1'b1; bus.d__addr = 16'h0700; bus.d__size = 16'd16;
    @(negedge clk); #3;
    chk("drop_pre_read", bus.m__read_m, 1);
    @(negedge clk);
    bus.d__read_m = 1'b0;
    #3;
    chk("drop_read_low", bus.m__read_m, 0);
    chk("drop_grant_held", bus.o__grant, 2);
    @(negedge clk);
    stray = 1'b1;
    #3 chk("drop_ready", bus.d__ready, 1);
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("drop_count", bus.o__d_grants, 8);
    chk("drop_grant_idle", bus.o__grant, 0);

    // saturation: preload D counter near the top, then three completions
    @(negedge clk);
    preset_req = 1'b1;
    @(posedge clk); #1;
    force dut.d_grants = 16'hFFFD;
    @(negedge clk);
    release dut.d_grants;
    preset_req = 1'b0;
    #3 chk("sat_preload", bus.o__d_grants, 16'hFFFD);
    mem_en = 1'b1; mem_lat = 1;
    d_txn(1'b1, 1'b0, 16'h0800, 16'd64, 64'h0);
    d_txn(1'b1, 1'b0, 16'h0808, 16'd64, 64'h0);
    d_txn(1'b0, 1'b1, 16'h0810, 16'd16, 64'h9);
    chk("sat_d_count", bus.o__d_grants, 16'hFFFF);
    chk("sat_i_count", bus.o__i_grants, 3);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
